pipe_seq_ctrl: RTL
==================

// Module: pipe_seq_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32 pipeline (F,D,X,M,W).
//  Consumes the hazard unit's load-use request, the X-stage branch redirect and the data-memory busy signal.
//  Drives the PC/pipeline-register enables, the per-stage valid bits and the reg-file/data-mem write gates.
//  Sits beside the hazard unit in the core top; forwarding selects stay in the hazard unit.
// PARAMETERS
//  LU_BUBBLES   1    bubbles inserted per load-use stall (1..3)
//  FLUSH_LAT    1    extra cycles fetch is squashed after a redirect (0..3)
//  MEM_TIMEOUT  255  max consecutive mem_busy cycles before mem_err (8-bit counter)
// PORTS
//  clk            in   1  core clock, rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  start          in   1  pulse: leave IDLE/HALTED, begin fetching
//  halt_req       in   1  level: stop fetch, drain pipe
//  load_use       in   1  D-stage instr needs X-stage load result
//  redirect       in   1  branch/jump taken, resolved in X
//  mem_busy       in   1  data memory not ready (M stage)
//  pc_en          out  1  load PC (sequential or redirect target)
//  pc_redirect    out  1  PC mux selects X-stage target
//  fd_en,dx_en    out  1  F/D, D/X register enables
//  xm_en,mw_en    out  1  X/M, M/W register enables
//  valid_d..w     out  4  {valid_w,valid_m,valid_x,valid_d}
//  reg_we_gate    out  1  = valid_w; ANDed with W-stage reg_wn
//  mem_we_gate    out  1  = valid_m; ANDed with M-stage mem_we
//  halted         out  1  pipeline empty in HALTED
//  mem_err        out  1  sticky: MEM_TIMEOUT exceeded
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all enables 0, valids 0, halted 0, mem_err 0, counters 0.
//  States: IDLE, RUN, LU_STALL, FLUSH, MEM_WAIT, DRAIN, HALTED (3-bit encoding).
//  IDLE: enables 0; start -> RUN.
//  RUN advance: all enables 1; valid_d<=1, valid_x<=valid_d, valid_m<=valid_x, valid_w<=valid_m.
//  Event priority in RUN/LU_STALL/FLUSH: mem_busy > redirect > load_use > halt_req.
//  mem_busy: all enables 0, valids hold -> MEM_WAIT; exit to RUN the cycle after mem_busy=0.
//   Counter increments per busy cycle; at MEM_TIMEOUT set mem_err (sticky until reset), stay in MEM_WAIT.
//   Redirect/load_use arriving during MEM_WAIT are ignored; X/D regs are frozen so they reappear on exit.
//  redirect (X valid only): pc_en=1, pc_redirect=1, all enables 1; valid_d<=0, valid_x<=0, M/W shift.
//   FLUSH_LAT=0 -> RUN next cycle; else FLUSH for FLUSH_LAT cycles: advance with valid_d<=0.
//  load_use (D valid, no redirect): pc_en=fd_en=0, dx_en..mw_en=1, valid_x<=0, M/W shift.
//   Held LU_BUBBLES cycles (LU_STALL, counter), then RUN; redirect in LU_STALL preempts -> flush path.
//  redirect ignored when valid_x=0; load_use ignored when valid_d=0.
//  halt_req: pc_en=0, valid_d<=0, others shift -> DRAIN; when valid_x|m|w all 0 -> HALTED, halted=1.
//   redirect during DRAIN still squashes D/X but does not refetch (pc_en=1 target load only, valid_d<=0).
//  HALTED: enables 0; start (halt_req=0) -> RUN; start with halt_req=1 ignored.
//  Outputs combinational from state + registered valids; no comb path from mem_busy to valids.
//  Reset mid-operation: all in-flight valids dropped, no write gate asserted the cycle after rst_n rises.
// STRUCTURE
//  Shared package core_pkg: state enum, stage index constants (ST_F..ST_W), valid-vector width.
//  One sub-module: pipe_valid_shift (4-bit valid register, shift/bubble/kill/hold controls).
//  FSM + LU/flush/timeout counters in top.
// TESTING
//  T1 reset+start, 6 cycles no hazards -> valid = 0001,0011,0111,1111 on cycles 1-4; reg_we_gate from cycle 4.
//  T2 load_use 1 cycle in RUN, LU_BUBBLES=1 -> pc_en=0 one cycle, valid_x=0 next, valid_w=0 three cycles later.
//  T3 redirect with FLUSH_LAT=1 -> pc_redirect=1 one cycle, valid_d,valid_x=0, two invalid D entries, no mem_we_gate.
//  T4 mem_busy 3 cycles with redirect held -> enables 0 for 3 cycles, valids unchanged, redirect taken cycle 4.
//  T5 mem_busy 300 cycles, MEM_TIMEOUT=255 -> mem_err rises after 255 busy cycles, stays 1 after busy drops.
//  T6 halt_req in full pipe -> halted=1 after 4 cycles, valids 0000; start -> RUN; rst_n low mid-run clears all.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline definitions for the RV32 core: stage indices, valid-vector layout
// and the stall/flush sequencer state encoding.
package core_pkg;

  localparam int ST_F = 0;
  localparam int ST_D = 1;
  localparam int ST_X = 2;
  localparam int ST_M = 3;
  localparam int ST_W = 4;

  // Fetch carries no valid bit, so the valid vector starts at D.
  localparam int VLD_W = ST_W - ST_F;
  localparam int VB_D  = ST_D - ST_F - 1;
  localparam int VB_X  = ST_X - ST_F - 1;
  localparam int VB_M  = ST_M - ST_F - 1;
  localparam int VB_W  = ST_W - ST_F - 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_LU_STALL = 3'd2,
    S_FLUSH    = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_DRAIN    = 3'd5,
    S_HALTED   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/pipe_valid_shift.sv
// Per-stage valid bits {W,M,X,D}. D loads independently of the X/M/W shift so a
// load-use stall can hold D while a bubble enters X.
module pipe_valid_shift
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_d,
  input  logic             d_in,
  input  logic             en_xmw,
  input  logic             kill_x,
  output logic [VLD_W-1:0] vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (en_d) begin
        vld[VB_D] <= d_in;
      end
      if (en_xmw) begin
        vld[VB_X] <= kill_x ? 1'b0 : vld[VB_D];
        vld[VB_M] <= vld[VB_X];
        vld[VB_W] <= vld[VB_M];
      end
    end
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: turns load-use, redirect and
// data-memory busy into register enables, stage valids and write gates.
module pipe_seq_ctrl
  import core_pkg::*;
#(
  parameter int LU_BUBBLES  = 1,
  parameter int FLUSH_LAT   = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             load_use,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic [VLD_W-1:0] valid,
  output logic             reg_we_gate,
  output logic             mem_we_gate,
  output logic             halted,
  output logic             mem_err
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  seq_state_e       state, state_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic [7:0]       busy_cnt;
  logic [VLD_W-1:0] vld;
  logic             pipe_en, d_in, kill_x;
  logic             take_redirect, take_lu, busy_track;

  assign take_redirect = redirect & vld[VB_X];
  assign take_lu       = load_use & vld[VB_D];
  assign busy_track    = (state != S_IDLE) && (state != S_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    fd_en       = 1'b0;
    pipe_en     = 1'b0;
    d_in        = 1'b0;
    kill_x      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_HALTED: begin
        if (start && !halt_req) state_nxt = S_RUN;
      end
      default: begin
        // A busy memory freezes everything; the cycle it clears behaves like RUN.
        if (mem_busy) begin
          state_nxt = S_MEM_WAIT;
        end else if (take_redirect) begin
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
          fd_en       = 1'b1;
          pipe_en     = 1'b1;
          kill_x      = 1'b1;
          if (state != S_DRAIN) begin
            if (FLUSH_LAT == 0) begin
              state_nxt = S_RUN;
            end else begin
              state_nxt = S_FLUSH;
              cnt_nxt   = 2'(FLUSH_LAT - 1);
            end
          end
        end else if (state == S_DRAIN) begin
          fd_en   = 1'b1;
          pipe_en = 1'b1;
          if (!(vld[VB_D] | vld[VB_X] | vld[VB_M])) state_nxt = S_HALTED;
        end else if (state == S_LU_STALL) begin
          pipe_en = 1'b1;
          kill_x  = 1'b1;
          if (cnt == 2'd0) state_nxt = S_RUN;
          else             cnt_nxt   = cnt - 2'd1;
        end else if (take_lu) begin
          pipe_en = 1'b1;
          kill_x  = 1'b1;
          if (LU_BUBBLES <= 1) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_LU_STALL;
            cnt_nxt   = 2'(LU_BUBBLES - 2);
          end
        end else if (halt_req) begin
          fd_en     = 1'b1;
          pipe_en   = 1'b1;
          state_nxt = S_DRAIN;
        end else if (state == S_FLUSH) begin
          pc_en   = 1'b1;
          fd_en   = 1'b1;
          pipe_en = 1'b1;
          if (cnt == 2'd0) state_nxt = S_RUN;
          else             cnt_nxt   = cnt - 2'd1;
        end else begin
          pc_en     = 1'b1;
          fd_en     = 1'b1;
          pipe_en   = 1'b1;
          d_in      = 1'b1;
          state_nxt = S_RUN;
        end
      end
    endcase
  end

  // Consecutive busy cycles; the counter saturates while mem_err stays sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (mem_busy && busy_track) begin
      if (busy_cnt != 8'hFF) busy_cnt <= busy_cnt + 8'd1;
      if (busy_cnt >= TO_LAST) mem_err <= 1'b1;
    end else begin
      busy_cnt <= '0;
    end
  end

  pipe_valid_shift u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .en_d  (fd_en),
    .d_in  (d_in),
    .en_xmw(pipe_en),
    .kill_x(kill_x),
    .vld   (vld)
  );

  assign dx_en       = pipe_en;
  assign xm_en       = pipe_en;
  assign mw_en       = pipe_en;
  assign valid       = vld;
  assign reg_we_gate = vld[VB_W];
  assign mem_we_gate = vld[VB_M];
  assign halted      = (state == S_HALTED);

endmodule
